// File: rtl/cakegame_uc.sv
// cakegame_uc: control unit for the cake memory game.
// For each of the 16 recipe steps it shows one ingredient, waits for a
// button press or a timeout, scores the press and advances the address.
//
// Ports:
//   clock, reset_n          system clock, synchronous active-low reset
//   start                   level, begins a game from IDLE or FINAL
//   end_mem_counter         address counter at its last step (15)
//   correct_play            registered play matches the memory word
//   has_play                one-cycle button-press pulse
//   end_show, half_show     show timer terminal count / past midpoint
//   timeout                 play timer terminal count
//   points[2:0]             current score
//   out_sel[1:0]            display select: 0 blank, 1 memory, 2 buttons
//   clear_*/enable_*        datapath register/counter controls
//   enable_timeout_counter  play timer run (low clears the timer)
//   done, win               game over / score reached WIN_POINTS
//   db_state[3:0]           state code for debug
module cakegame_uc #(
  parameter int WIN_POINTS = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       end_mem_counter,
  input  logic       correct_play,
  input  logic       has_play,
  input  logic       end_show,
  input  logic       half_show,
  input  logic       timeout,
  input  logic [2:0] points,
  output logic [1:0] out_sel,
  output logic       clear_reg,
  output logic       enable_reg,
  output logic       clear_mem_counter,
  output logic       enable_mem_counter,
  output logic       clear_show_counter,
  output logic       enable_show_counter,
  output logic       enable_timeout_counter,
  output logic       clear_points_counter,
  output logic       enable_points_counter,
  output logic       done,
  output logic       win,
  output logic [3:0] db_state
);

  localparam logic [2:0] WIN_P = 3'(WIN_POINTS);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PREP      = 4'd1,
    LOAD      = 4'd2,
    SHOW      = 4'd3,
    WAIT_PLAY = 4'd4,
    REGISTER  = 4'd5,
    COMPARE   = 4'd6,
    NEXT      = 4'd7,
    FINAL     = 4'd8
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt              = state;
    out_sel                = 2'd0;
    clear_reg              = 1'b0;
    enable_reg             = 1'b0;
    clear_mem_counter      = 1'b0;
    enable_mem_counter     = 1'b0;
    clear_show_counter     = 1'b0;
    enable_show_counter    = 1'b0;
    enable_timeout_counter = 1'b0;
    clear_points_counter   = 1'b0;
    enable_points_counter  = 1'b0;
    done                   = 1'b0;
    win                    = 1'b0;
    case (state)
      PREP: begin
        clear_reg            = 1'b1;
        clear_mem_counter    = 1'b1;
        clear_show_counter   = 1'b1;
        clear_points_counter = 1'b1;
        state_nxt            = LOAD;
      end
      // one cycle for the synchronous ROM to present the new word
      LOAD: begin
        clear_show_counter = 1'b1;
        state_nxt          = SHOW;
      end
      // ingredient is only visible for the first half of the show period
      SHOW: begin
        enable_show_counter = 1'b1;
        out_sel             = half_show ? 2'd0 : 2'd1;
        if (end_show) state_nxt = WAIT_PLAY;
      end
      // a press beats a simultaneous timeout
      WAIT_PLAY: begin
        enable_timeout_counter = 1'b1;
        out_sel                = 2'd2;
        if (has_play)     state_nxt = REGISTER;
        else if (timeout) state_nxt = NEXT;
      end
      REGISTER: begin
        enable_reg = 1'b1;
        out_sel    = 2'd2;
        state_nxt  = COMPARE;
      end
      // score saturates at 7
      COMPARE: begin
        enable_points_counter = correct_play & (points != 3'd7);
        state_nxt             = NEXT;
      end
      // address stays at 15 after the last step
      NEXT: begin
        clear_reg = 1'b1;
        if (end_mem_counter) begin
          state_nxt = FINAL;
        end else begin
          enable_mem_counter = 1'b1;
          state_nxt          = LOAD;
        end
      end
      FINAL: begin
        done = 1'b1;
        win  = (points >= WIN_P);
        if (start) state_nxt = PREP;
      end
      // IDLE, and any illegal code, which falls back to IDLE
      default: begin
        clear_reg            = 1'b1;
        clear_mem_counter    = 1'b1;
        clear_show_counter   = 1'b1;
        clear_points_counter = 1'b1;
        if (state == IDLE) state_nxt = start ? PREP : IDLE;
        else               state_nxt = IDLE;
      end
    endcase
  end

  assign db_state = state;

endmodule

// File: tb/tb_cakegame_uc.sv
module tb_cakegame_uc;
  logic clock = 1'b0;
  logic reset_n, start, end_mem_counter, correct_play, has_play;
  logic end_show, half_show, timeout;
  logic [2:0] points;
  logic [1:0] out_sel;
  logic clear_reg, enable_reg, clear_mem_counter, enable_mem_counter;
  logic clear_show_counter, enable_show_counter, enable_timeout_counter;
  logic clear_points_counter, enable_points_counter, done, win;
  logic [3:0] db_state;

  always #5 clock = ~clock;

  cakegame_uc #(.WIN_POINTS(5)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .end_mem_counter(end_mem_counter), .correct_play(correct_play),
    .has_play(has_play), .end_show(end_show), .half_show(half_show),
    .timeout(timeout), .points(points), .out_sel(out_sel),
    .clear_reg(clear_reg), .enable_reg(enable_reg),
    .clear_mem_counter(clear_mem_counter), .enable_mem_counter(enable_mem_counter),
    .clear_show_counter(clear_show_counter), .enable_show_counter(enable_show_counter),
    .enable_timeout_counter(enable_timeout_counter),
    .clear_points_counter(clear_points_counter), .enable_points_counter(enable_points_counter),
    .done(done), .win(win), .db_state(db_state)
  );

  // flag bit positions in the packed control word
  localparam logic [10:0] F_CR = 11'h400, F_ER = 11'h200, F_CM = 11'h100, F_EM = 11'h080,
                          F_CS = 11'h040, F_ES = 11'h020, F_ET = 11'h010, F_CP = 11'h008,
                          F_EP = 11'h004, F_DN = 11'h002, F_WN = 11'h001;
  localparam logic [10:0] F_CLR = F_CR | F_CM | F_CS | F_CP;

  typedef struct {
    logic rn, st, em, cp, hp, es, hs, to;
    logic [2:0] pts;
    logic [3:0] xs;
    logic [1:0] xsel;
    logic [10:0] xf;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0, nerr = 0;

  function automatic logic [16:0] dut_word();
    return {db_state, out_sel, clear_reg, enable_reg, clear_mem_counter, enable_mem_counter,
            clear_show_counter, enable_show_counter, enable_timeout_counter,
            clear_points_counter, enable_points_counter, done, win};
  endfunction

  task automatic add(input logic rn, st, em, cp, hp, es, hs, to, input logic [2:0] pts,
                     input logic [3:0] xs, input logic [1:0] xsel, input logic [10:0] xf);
    vec_t v;
    v.rn = rn; v.st = st; v.em = em; v.cp = cp; v.hp = hp; v.es = es; v.hs = hs; v.to = to;
    v.pts = pts; v.xs = xs; v.xsel = xsel; v.xf = xf;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rn, st, em, cp, hp, es, hs, to, input logic [2:0] pts);
    reset_n = rn; start = st; end_mem_counter = em; correct_play = cp; has_play = hp;
    end_show = es; half_show = hs; timeout = to; points = pts;
  endtask

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = dut_word();
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
               name, act[16:13], act[12:0], exp[16:13], exp[12:0]);
    end
  endtask

  // ---- reference model: spec rules as tables of per-phase behaviour ----
  // base flags shown in each phase (index = phase code); Mealy terms added separately
  logic [10:0] base_flags [0:8];
  logic [1:0]  base_sel   [0:8];
  initial begin
    base_flags = '{F_CLR, F_CLR, F_CS, F_ES, F_ET, F_ER, 11'h0, F_CR, F_DN};
    base_sel   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
  end

  function automatic int model_next(int s);
    case (s)
      0: return start ? 1 : 0;
      1: return 2;
      2: return 3;
      3: return end_show ? 4 : 3;
      4: return has_play ? 5 : (timeout ? 7 : 4);
      5: return 6;
      6: return 7;
      7: return end_mem_counter ? 8 : 2;
      8: return start ? 1 : 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [16:0] model_out(int s);
    logic [10:0] f;
    logic [1:0] sel;
    f = base_flags[s];
    sel = base_sel[s];
    if (s == 3 && !half_show) sel = 2'd1;
    if (s == 6 && correct_play && points < 3'd7) f |= F_EP;
    if (s == 7 && !end_mem_counter) f |= F_EM;
    if (s == 8 && int'(points) >= 5) f |= F_WN;
    return {4'(s), sel, f};
  endfunction

  initial begin
    int ms;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd0);

    //   rn st em cp hp es hs to pts   state sel flags
    add(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 2'd0, F_CLR);
    add(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 4'd1, 2'd0, F_CLR);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd2, 2'd0, F_CS);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd3, 2'd1, F_ES);
    add(1, 1, 0, 0, 1, 0, 0, 0, 3'd0, 4'd3, 2'd1, F_ES);         // start/has_play ignored
    add(1, 0, 0, 0, 0, 0, 1, 0, 3'd0, 4'd3, 2'd0, F_ES);         // past midpoint: blank
    add(1, 0, 0, 0, 0, 1, 1, 0, 3'd0, 4'd4, 2'd2, F_ET);
    add(1, 0, 0, 0, 1, 0, 0, 1, 3'd0, 4'd5, 2'd2, F_ER);         // press beats timeout
    add(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 4'd6, 2'd0, F_EP);
    add(1, 0, 0, 1, 0, 0, 0, 0, 3'd3, 4'd7, 2'd0, F_CR | F_EM);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd3, 4'd2, 2'd0, F_CS);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd3, 4'd3, 2'd1, F_ES);
    add(1, 0, 0, 0, 0, 1, 0, 0, 3'd3, 4'd4, 2'd2, F_ET);
    add(1, 0, 1, 0, 0, 0, 0, 1, 3'd3, 4'd7, 2'd0, F_CR);         // last step: no increment
    add(1, 0, 1, 0, 0, 0, 0, 0, 3'd5, 4'd8, 2'd0, F_DN | F_WN);
    add(1, 0, 1, 0, 0, 0, 0, 0, 3'd4, 4'd8, 2'd0, F_DN);
    add(1, 1, 1, 0, 0, 0, 0, 0, 3'd4, 4'd1, 2'd0, F_CLR);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd2, 2'd0, F_CS);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd3, 2'd1, F_ES);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 2'd0, F_CLR);        // reset mid-SHOW
    // saturation at 7, then a timeout-only step
    add(1, 1, 0, 0, 0, 0, 0, 0, 3'd7, 4'd1, 2'd0, F_CLR);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd7, 4'd2, 2'd0, F_CS);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd7, 4'd3, 2'd1, F_ES);
    add(1, 0, 0, 0, 0, 1, 0, 0, 3'd7, 4'd4, 2'd2, F_ET);
    add(1, 0, 0, 0, 1, 0, 0, 0, 3'd7, 4'd5, 2'd2, F_ER);
    add(1, 0, 0, 1, 0, 0, 0, 0, 3'd7, 4'd6, 2'd0, 11'h0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 3'd7, 4'd7, 2'd0, F_CR | F_EM);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd7, 4'd2, 2'd0, F_CS);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd7, 4'd3, 2'd1, F_ES);
    add(1, 0, 0, 0, 0, 1, 0, 0, 3'd7, 4'd4, 2'd2, F_ET);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3'd7, 4'd4, 2'd2, F_ET);         // keep waiting
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'd7, 4'd7, 2'd0, F_CR | F_EM);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      drive(tbl[i].rn, tbl[i].st, tbl[i].em, tbl[i].cp, tbl[i].hp,
            tbl[i].es, tbl[i].hs, tbl[i].to, tbl[i].pts);
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), {tbl[i].xs, tbl[i].xsel, tbl[i].xf});
    end

    // randomized run against the model
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
    @(posedge clock); #1;
    ms = 0;
    check("rnd_reset", model_out(ms));
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      drive(($urandom_range(63) != 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
            1'($urandom), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
            1'($urandom), ($urandom_range(7) == 0), 3'($urandom));
      @(posedge clock);
      ms = reset_n ? model_next(ms) : 0;
      #1;
      check($sformatf("rnd%0d", c), model_out(ms));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
